// File: rtl/dlx_alu_seq.sv
// ============================================================================
// dlx_alu_seq -- handshaked DLX execute-stage ALU with optional iterative
// unsigned multiplier.
//
// One operation is accepted per cycle when ex && ex_ready. Single-cycle
// operations register their result and flags at the accepting edge and pulse
// res_valid for one cycle. MULU (opcode C) runs a shift-add multiplier for
// WIDTH cycles while ex_ready is held low.
//
// Parameters:
//   WIDTH     operand/result width (8..64, power of two)
//   SHW       shift-amount width, derived as $clog2(WIDTH)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   ex         in   request valid
//   ex_ready   out  unit can accept a request this cycle
//   op         in   4-bit opcode, sampled on accept
//   op1, op2   in   WIDTH-bit operands, sampled on accept
//   res        out  WIDTH-bit result, held until the next completion
//   res_valid  out  one-cycle pulse marking a new res and flags
//   carry      out  carry-out (ADD), borrow (SUB), high-bits-nonzero (MULU)
//   z          out  res == 0
//   ovf        out  two's-complement overflow on ADD/SUB
//   err        out  reserved opcode was executed
//
// Configuration macro:
//   DLX_ALU_MUL_EN  defined: MULU supported via the MUL state.
//                   undefined: opcode C is reserved, ex_ready is always 1.
// ============================================================================
module dlx_alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex,
    output logic             ex_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] res,
    output logic             res_valid,
    output logic             carry,
    output logic             z,
    output logic             ovf,
    output logic             err
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
        OP_XOR  = 4'h4, OP_SLL  = 4'h5, OP_SRL  = 4'h6, OP_SRA  = 4'h7,
        OP_SLT  = 4'h8, OP_SLTU = 4'h9, OP_SEQ  = 4'hA, OP_SNE  = 4'hB,
        OP_MULU = 4'hC
    } op_e;

    logic             w_accept;
    logic             w_is_mul;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_err;

    logic [WIDTH-1:0] r_res;
    logic             r_res_valid;
    logic             r_carry;
    logic             r_z;
    logic             r_ovf;
    logic             r_err;

    assign w_accept = ex && ex_ready;
    assign w_add    = {1'b0, op1} + {1'b0, op2};
    // Top bit of the widened difference is the unsigned borrow.
    assign w_sub    = {1'b0, op1} - {1'b0, op2};
    assign w_shamt  = op2[SHW-1:0];

    // Single-cycle datapath. Opcode C lands in the reserved branch here; when
    // the multiplier is compiled in, its accept is routed to the MUL state and
    // this result is never registered.
    // NOTE: every output of a combinational block gets a default first so that
    // no path through the case statement leaves a value unassigned (no latch).
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (op)
            OP_ADD: begin
                w_res   = w_add[WIDTH-1:0];
                w_carry = w_add[WIDTH];
                w_ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                          (w_add[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_SUB: begin
                w_res   = w_sub[WIDTH-1:0];
                w_carry = w_sub[WIDTH];
                w_ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                          (w_sub[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_AND:  w_res = op1 & op2;
            OP_OR:   w_res = op1 | op2;
            OP_XOR:  w_res = op1 ^ op2;
            OP_SLL:  w_res = op1 << w_shamt;
            OP_SRL:  w_res = op1 >> w_shamt;
            OP_SRA:  w_res = WIDTH'($signed(op1) >>> w_shamt);
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            OP_SEQ:  w_res = {{(WIDTH-1){1'b0}}, (op1 == op2)};
            OP_SNE:  w_res = {{(WIDTH-1){1'b0}}, (op1 != op2)};
            default: w_err = 1'b1;
        endcase
    end

`ifdef DLX_ALU_MUL_EN
    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_e;

    state_e           r_state;
    state_e           w_next;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH:0]   w_step;
    logic [WIDTH-1:0] w_prod_hi;
    logic [WIDTH-1:0] w_prod_lo;
    logic             w_mul_done;

    assign w_is_mul = (op == OP_MULU);

    // Right-shifting shift-add: {hi, lo} starts as {0, multiplier}; each step
    // adds the multiplicand to hi when lo[0] is set, then shifts the pair right.
    // After WIDTH steps {hi, lo} holds the full 2*WIDTH-bit product.
    assign w_step     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_hi  = w_step[WIDTH:1];
    assign w_prod_lo  = {w_step[0], r_lo[WIDTH-1:1]};
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == '0);

    // NOTE: sequential state uses non-blocking assignments and an asynchronous
    // active-low reset so every register updates together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        ex_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                ex_ready = 1'b1;
                if (w_accept && w_is_mul) w_next = S_MUL;
            end
            S_MUL: begin
                if (r_cnt == '0) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (w_accept && w_is_mul) begin
            r_cnt   <= SHW'(WIDTH - 1);
            r_mcand <= op1;
            r_hi    <= '0;
            r_lo    <= op2;
        end else if (r_state == S_MUL) begin
            r_cnt   <= r_cnt - 1'b1;
            r_hi    <= w_prod_hi;
            r_lo    <= w_prod_lo;
        end
    end
`else
    assign w_is_mul = 1'b0;
    assign ex_ready = 1'b1;
`endif

    // Result/flag register: written only on a completion, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_carry     <= 1'b0;
            r_z         <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            if (w_accept && !w_is_mul) begin
                r_res       <= w_res;
                r_res_valid <= 1'b1;
                r_carry     <= w_carry;
                r_z         <= (w_res == '0);
                r_ovf       <= w_ovf;
                r_err       <= w_err;
            end
`ifdef DLX_ALU_MUL_EN
            else if (w_mul_done) begin
                r_res       <= w_prod_lo;
                r_res_valid <= 1'b1;
                r_carry     <= |w_prod_hi;
                r_z         <= (w_prod_lo == '0);
                r_ovf       <= 1'b0;
                r_err       <= 1'b0;
            end
`endif
        end
    end

    assign res       = r_res;
    assign res_valid = r_res_valid;
    assign carry     = r_carry;
    assign z         = r_z;
    assign ovf       = r_ovf;
    assign err       = r_err;

endmodule

// File: tb/tb_dlx_alu_seq.sv
// ============================================================================
// tb_dlx_alu_seq -- self-checking bench for dlx_alu_seq at WIDTH = 32.
// Directed cases from the ALU's documented behaviour, then randomized
// operations checked against an arithmetic reference model.
// Works with DLX_ALU_MUL_EN either defined or undefined.
// ============================================================================
module tb_dlx_alu_seq;

    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          ex;
    logic          ex_ready;
    logic [3:0]    op;
    logic [W-1:0]  op1;
    logic [W-1:0]  op2;
    logic [W-1:0]  res;
    logic          res_valid;
    logic          carry;
    logic          z;
    logic          ovf;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         carry;
        logic         z;
        logic         ovf;
        logic         err;
        int           lat;
    } exp_t;

    dlx_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex        (ex),
        .ex_ready  (ex_ready),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .res       (res),
        .res_valid (res_valid),
        .carry     (carry),
        .z         (z),
        .ovf       (ovf),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

`ifdef DLX_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    // Reference model: plain integer arithmetic on the opcode rules.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint sa, sb, sr;
        longint unsigned ua, ub, p, hi;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        sh = int'(b % W);
        e.res = '0; e.carry = 0; e.ovf = 0; e.err = 0; e.lat = 0;
        case (o)
            4'h0: begin
                p = ua + ub; e.res = W'(p); e.carry = (p >= 64'h1_0000_0000);
                sr = sa + sb; e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'h1: begin
                e.res = a - b; e.carry = (ua < ub);
                sr = sa - sb; e.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'h2: e.res = a & b;
            4'h3: e.res = a | b;
            4'h4: e.res = a ^ b;
            4'h5: e.res = W'(ua * (64'd1 << sh));
            4'h6: e.res = W'(ua / (64'd1 << sh));
            4'h7: begin
                // Arithmetic shift = floor division by 2^sh.
                sr = sa;
                for (int i = 0; i < sh; i++) sr = (sr < 0) ? -((-sr + 1) / 2) : sr / 2;
                e.res = W'(sr);
            end
            4'h8: e.res = (sa < sb) ? 1 : 0;
            4'h9: e.res = (ua < ub) ? 1 : 0;
            4'hA: e.res = (a == b) ? 1 : 0;
            4'hB: e.res = (a != b) ? 1 : 0;
            4'hC: begin
                if (MUL_EN) begin
                    p = ua * ub; hi = p >> W;
                    e.res = W'(p); e.carry = (hi != 0); e.lat = W;
                end else begin
                    e.err = 1;
                end
            end
            default: e.err = 1;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    // Drive a request, wait (bounded) for accept, then release ex.
    task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        @(negedge clk);
        ex = 1'b1; op = o; op1 = a; op2 = b;
        n = 0;
        while (!ex_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n >= 200), 64'(0));
        @(posedge clk);
        #1;
        ex = 1'b0;
    endtask

    // Called #1 after the accepting edge: wait for res_valid and compare.
    task automatic expect_result(input string tag, input exp_t e);
        int lat;
        lat = 0;
        while (!res_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".lat"},   64'(lat),   64'(e.lat));
        check({tag, ".res"},   64'(res),   64'(e.res));
        check({tag, ".carry"}, 64'(carry), 64'(e.carry));
        check({tag, ".z"},     64'(z),     64'(e.z));
        check({tag, ".ovf"},   64'(ovf),   64'(e.ovf));
        check({tag, ".err"},   64'(err),   64'(e.err));
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        send(o, a, b);
        expect_result(tag, model(o, a, b));
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return W'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]   b2b_op [4];
        logic [W-1:0] b2b_a  [4];
        logic [W-1:0] b2b_b  [4];
        int rdy_low, lat, n_valid;
        exp_t e;

        rst_n = 1'b0; ex = 1'b0; op = '0; op1 = '0; op2 = '0;
        #12;
        check("rst.res",       64'(res),       64'(0));
        check("rst.res_valid", 64'(res_valid), 64'(0));
        check("rst.flags",     64'({carry, z, ovf, err}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.ex_ready", 64'(ex_ready), 64'(1));

        // Basic and boundary arithmetic.
        run_op("add_11_2", 4'h0, 32'd11, 32'd2);
        @(posedge clk); #1;
        check("add_11_2.pulse_drop", 64'(res_valid), 64'(0));
        run_op("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'h1);
        run_op("sub_ovf",  4'h1, 32'h8000_0000, 32'h1);

        // Back-to-back stream: one result per cycle, in issue order.
        b2b_op = '{4'h7, 4'h5, 4'h8, 4'h9};
        b2b_a  = '{32'h8000_0000, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        b2b_b  = '{32'h4, 32'h25, 32'h1, 32'h1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ex = 1'b1; op = b2b_op[i]; op1 = b2b_a[i]; op2 = b2b_b[i];
            @(posedge clk); #1;
            e = model(b2b_op[i], b2b_a[i], b2b_b[i]);
            check($sformatf("b2b%0d.valid", i), 64'(res_valid), 64'(1));
            check($sformatf("b2b%0d.res", i),   64'(res),       64'(e.res));
        end
        ex = 1'b0;
        @(posedge clk); #1;
        check("b2b.pulse_drop", 64'(res_valid), 64'(0));

        if (MUL_EN) begin
            // MULU with a second request held during the busy window.
            @(negedge clk);
            ex = 1'b1; op = 4'hC; op1 = 32'd11; op2 = 32'd2;
            @(posedge clk); #1;
            op = 4'h0; op1 = 32'd5; op2 = 32'd6;
            rdy_low = 0; lat = 0;
            while (!res_valid && lat < 200) begin
                if (!ex_ready) rdy_low++;
                @(posedge clk); #1;
                lat++;
            end
            check("mul_hold.lat",     64'(lat),     64'(W));
            check("mul_hold.busy",    64'(rdy_low), 64'(W));
            check("mul_hold.res",     64'(res),     64'(22));
            check("mul_hold.ready",   64'(ex_ready), 64'(1));
            @(posedge clk); #1;
            ex = 1'b0;
            check("held_add.valid", 64'(res_valid), 64'(1));
            check("held_add.res",   64'(res),       64'(11));
            run_op("mul_hi", 4'hC, 32'h1_0000, 32'h1_0000);
        end else begin
            run_op("opc_reserved", 4'hC, 32'd11, 32'd2);
        end

        // Reserved opcode, then a legal op clears err.
        run_op("op_e", 4'hE, 32'h1234, 32'h5678);
        run_op("err_clear", 4'h0, 32'd1, 32'd1);

        // Reset asserted in the middle of an operation.
        run_op("pre_rst", 4'h0, 32'd3, 32'd9);
        if (MUL_EN) begin
            send(4'hC, 32'hFFFF, 32'hFFFF);
            repeat (10) @(posedge clk);
            #2;
        end
        rst_n = 1'b0;
        #1;
        check("midrst.res",   64'(res),       64'(0));
        check("midrst.valid", 64'(res_valid), 64'(0));
        check("midrst.flags", 64'({carry, z, ovf, err}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (res_valid) n_valid++;
        end
        check("midrst.no_valid", 64'(n_valid),  64'(0));
        check("midrst.ready",    64'(ex_ready), 64'(1));
        run_op("post_rst_add", 4'h0, 32'd3, 32'd4);

        // Randomized operations against the reference model.
        for (int i = 0; i < 250; i++) begin
            logic [3:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 4'($urandom_range(0, 15));
            ra = pick_operand();
            rb = pick_operand();
            run_op($sformatf("rnd%0d_op%0h", i, ro), ro, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
